// File: rtl/rx_adc_deser_pkg.sv
// Shared types and width helpers for the RX ADC deserializer.
// Imported by the frame FIFO and the deserializer top.
package rx_adc_deser_pkg;

    localparam int N_ADC_DEF = 8;

    typedef logic signed [N_ADC_DEF-1:0] code_t;

    function automatic int frame_w(input int n_ways, input int n_adc);
        return n_ways * n_adc;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_adc_deser_frame_fifo.sv
// Synchronous frame FIFO; pointers carry one extra wrap bit for full/empty.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module frame_fifo
    import rx_adc_deser_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    empty,
    output logic                    full,
    output logic [lvl_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[AW] != rd_ptr[AW]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is shown straight from storage; no fall-through path from din.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/rx_adc_deser.sv
// Packs N_WAYS ADC codes per frame into a FIFO with valid/ready output,
// counting frames lost to a full FIFO; align restarts lane 0.
module rx_adc_deser
    import rx_adc_deser_pkg::*;
#(
    parameter int N_ADC      = 8,
    parameter int N_WAYS     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic [N_ADC-1:0]                  in_code,
    input  logic                              in_valid,
    input  logic                              align,
    output logic [frame_w(N_WAYS, N_ADC)-1:0] frame_data,
    output logic                              frame_valid,
    input  logic                              frame_ready,
    output logic [lvl_w(FIFO_DEPTH)-1:0]      fifo_level,
    output logic [DROP_CNT_W-1:0]             drop_cnt,
    output logic                              overflow_sticky,
    input  logic                              clr_stats
);

    localparam int FRAME_W = frame_w(N_WAYS, N_ADC);
    localparam int IW      = $clog2(N_WAYS);
    localparam logic [IW-1:0] LAST = IW'(N_WAYS - 1);
    localparam logic [DROP_CNT_W-1:0] CNT_MAX = '1;

    logic [IW-1:0]      idx;
    logic [FRAME_W-1:0] asm_q;
    logic [FRAME_W-1:0] frame_next;
    logic               complete;
    logic               empty;
    logic               full;
    logic               drop;

    always_comb begin
        frame_next = asm_q;
        frame_next[idx*N_ADC +: N_ADC] = in_code;
    end

    // Align takes priority over a coincident completion.
    assign complete    = in_valid && !align && (idx == LAST);
    assign frame_valid = !empty;
    assign drop        = complete && full && !frame_ready;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (align) begin
            idx   <= in_valid ? IW'(1) : '0;
            asm_q <= {{(FRAME_W-N_ADC){1'b0}}, in_valid ? in_code : '0};
        end else if (in_valid) begin
            asm_q <= frame_next;
            idx   <= complete ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            drop_cnt        <= '0;
            overflow_sticky <= 1'b0;
        end else if (clr_stats) begin
            drop_cnt        <= drop ? DROP_CNT_W'(1) : '0;
            overflow_sticky <= drop;
        end else if (drop) begin
            if (drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
            overflow_sticky <= 1'b1;
        end
    end

    frame_fifo #(
        .WIDTH(FRAME_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rstb (rstb),
        .push (complete),
        .din  (frame_next),
        .pop  (frame_ready),
        .dout (frame_data),
        .empty(empty),
        .full (full),
        .level(fifo_level)
    );

endmodule

// File: tb/tb_rx_adc_deser.sv
// Directed bench for rx_adc_deser with a frame scoreboard and a
// cycle model of lane index, FIFO occupancy and drop statistics.
module tb_rx_adc_deser;
    import rx_adc_deser_pkg::*;

    localparam int NA = 8;
    localparam int NW = 4;
    localparam int FD = 4;
    localparam int DW = 2;
    localparam int FW = NA * NW;

    logic          clk = 1'b0;
    logic          rstb;
    logic [NA-1:0] in_code;
    logic          in_valid;
    logic          align;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic [2:0]    fifo_level;
    logic [DW-1:0] drop_cnt;
    logic          overflow_sticky;
    logic          clr_stats;

    int errs   = 0;
    int checks = 0;

    logic [FW-1:0] sb[$];
    int            midx;
    logic [FW-1:0] masm;
    int            mdrop;
    bit            msticky;

    always #5 clk = ~clk;

    rx_adc_deser #(
        .N_ADC(NA),
        .N_WAYS(NW),
        .FIFO_DEPTH(FD),
        .DROP_CNT_W(DW)
    ) dut (
        .clk            (clk),
        .rstb           (rstb),
        .in_code        (in_code),
        .in_valid       (in_valid),
        .align          (align),
        .frame_data     (frame_data),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .fifo_level     (fifo_level),
        .drop_cnt       (drop_cnt),
        .overflow_sticky(overflow_sticky),
        .clr_stats      (clr_stats)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("level", 64'(fifo_level), 64'(sb.size()));
        chk("valid", 64'(frame_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) chk("head", 64'(frame_data), 64'(sb[0]));
        chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
        chk("sticky", 64'(overflow_sticky), 64'(msticky));
    endtask

    // Drive one cycle, check the state left by the previous edge,
    // then advance the model through this edge.
    task automatic cyc(input bit v, input code_t c, input bit al);
        logic [FW-1:0] f;
        bit comp;
        bit dr;
        in_valid = v;
        in_code  = c;
        align    = al;
        check_state();
        comp = 1'b0;
        dr   = 1'b0;
        f    = masm;
        f[midx*NA +: NA] = c;
        if (sb.size() != 0 && frame_ready) void'(sb.pop_front());
        if (al) begin
            masm = '0;
            if (v) masm[NA-1:0] = c;
            midx = v ? 1 : 0;
        end else if (v) begin
            masm = f;
            if (midx == NW - 1) begin
                comp = 1'b1;
                midx = 0;
            end else begin
                midx++;
            end
        end
        if (comp) begin
            if (sb.size() < FD) sb.push_back(f);
            else dr = 1'b1;
        end
        if (clr_stats) begin
            mdrop   = dr ? 1 : 0;
            msticky = dr;
        end else if (dr) begin
            if (mdrop < (1 << DW) - 1) mdrop++;
            msticky = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, code_t'($urandom), 1'b0);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NW; i++) cyc(1'b1, code_t'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        rstb     = 1'b0;
        in_valid = 1'b1;
        in_code  = 8'h5A;
        align    = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        midx    = 0;
        masm    = '0;
        mdrop   = 0;
        msticky = 1'b0;
        chk("rst_valid", 64'(frame_valid), 64'(0));
        chk("rst_data", 64'(frame_data), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_sticky", 64'(overflow_sticky), 64'(0));
        rstb     = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        rstb        = 1'b0;
        in_code     = '0;
        in_valid    = 1'b0;
        align       = 1'b0;
        frame_ready = 1'b0;
        clr_stats   = 1'b0;
        midx        = 0;
        masm        = '0;
        mdrop       = 0;
        msticky     = 1'b0;
        do_reset();
        idle(1);

        frame_ready = 1'b1;
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'hFE, 1'b0);
        cyc(1'b1, 8'h03, 1'b0);
        cyc(1'b1, 8'hFC, 1'b0);
        chk("basic_valid", 64'(frame_valid), 64'(1));
        chk("basic_data", 64'(frame_data), 64'h0000_0000_FC03_FE01);
        idle(1);
        chk("basic_level", 64'(fifo_level), 64'(0));

        cyc(1'b1, 8'h05, 1'b0);
        cyc(1'b0, 8'hAA, 1'b0);
        cyc(1'b0, 8'h55, 1'b0);
        cyc(1'b1, 8'h06, 1'b0);
        cyc(1'b1, 8'h07, 1'b0);
        cyc(1'b0, 8'h33, 1'b0);
        cyc(1'b1, 8'h08, 1'b0);
        chk("gap_data", 64'(frame_data), 64'h0000_0000_0807_0605);
        idle(1);

        cyc(1'b1, 8'h09, 1'b0);
        cyc(1'b1, 8'h0A, 1'b0);
        cyc(1'b1, 8'h0B, 1'b1);
        cyc(1'b1, 8'h0C, 1'b0);
        cyc(1'b1, 8'h0D, 1'b0);
        cyc(1'b1, 8'h0E, 1'b0);
        chk("align_data", 64'(frame_data), 64'h0000_0000_0E0D_0C0B);
        idle(1);
        chk("align_drop", 64'(drop_cnt), 64'(0));

        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        cyc(1'b1, 8'h03, 1'b0);
        cyc(1'b1, 8'h07, 1'b1);
        chk("align_last_valid", 64'(frame_valid), 64'(0));
        cyc(1'b1, 8'h08, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h03, 1'b0);
        cyc(1'b1, 8'h04, 1'b0);
        cyc(1'b1, 8'h05, 1'b0);
        cyc(1'b1, 8'h06, 1'b0);
        chk("align_idle_data", 64'(frame_data), 64'h0000_0000_0605_0403);
        idle(1);

        frame_ready = 1'b0;
        for (int i = 0; i < 6; i++) rand_frame();
        idle(1);
        chk("fill_level", 64'(fifo_level), 64'(4));
        chk("fill_drop", 64'(drop_cnt), 64'(2));
        chk("fill_sticky", 64'(overflow_sticky), 64'(1));
        frame_ready = 1'b1;
        idle(5);
        chk("drain_level", 64'(fifo_level), 64'(0));

        frame_ready = 1'b0;
        for (int i = 0; i < 4; i++) rand_frame();
        for (int i = 0; i < NW - 1; i++) cyc(1'b1, code_t'($urandom), 1'b0);
        frame_ready = 1'b1;
        cyc(1'b1, code_t'($urandom), 1'b0);
        frame_ready = 1'b0;
        chk("pushpop_level", 64'(fifo_level), 64'(4));
        chk("pushpop_drop", 64'(drop_cnt), 64'(2));

        for (int i = 0; i < NW - 1; i++) cyc(1'b1, code_t'($urandom), 1'b0);
        clr_stats = 1'b1;
        cyc(1'b1, code_t'($urandom), 1'b0);
        clr_stats = 1'b0;
        chk("clr_drop", 64'(drop_cnt), 64'(1));
        chk("clr_sticky", 64'(overflow_sticky), 64'(1));

        for (int i = 0; i < 3; i++) rand_frame();
        chk("sat_drop", 64'(drop_cnt), 64'(3));
        clr_stats = 1'b1;
        idle(1);
        clr_stats = 1'b0;
        chk("clr_only_drop", 64'(drop_cnt), 64'(0));
        chk("clr_only_sticky", 64'(overflow_sticky), 64'(0));
        frame_ready = 1'b1;
        idle(6);

        frame_ready = 1'b0;
        for (int i = 0; i < 3; i++) rand_frame();
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b1, 8'h66, 1'b0);
        chk("pre_rst_level", 64'(fifo_level), 64'(3));
        do_reset();
        frame_ready = 1'b1;
        cyc(1'b1, 8'h15, 1'b0);
        cyc(1'b1, 8'h16, 1'b0);
        cyc(1'b1, 8'h17, 1'b0);
        cyc(1'b1, 8'h18, 1'b0);
        chk("post_rst_data", 64'(frame_data), 64'h0000_0000_1817_1615);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rx_adc_deser.md
Name: rx_adc_deser

Overview:
Downstream consumer of the RX ADC: captures one signed ADC code per clock-enabled sample and packs N_WAYS consecutive codes into a parallel frame for the DSP datapath (FFE/slicer).
Frames are buffered in a small synchronous FIFO with a valid/ready output handshake. Frames that cannot be buffered are counted as drops.
An align input restarts framing so that the lane-0 position can be controlled by the link bring-up logic.

Parameters:
N_ADC, 8, ADC code width in bits (matches the ADC's n_adc)
N_WAYS, 16, samples per output frame (>=2)
FIFO_DEPTH, 4, frame FIFO entries (power of 2, >=2)
DROP_CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  sample/system clock; all state is updated on its rising edge
rstb  in  1  synchronous active-low reset
in_code  in  N_ADC  signed ADC code (two's complement)
in_valid  in  1  in_code is a valid sample this cycle
align  in  1  restart framing; the current partial frame is discarded
frame_data  out  N_WAYS*N_ADC  packed frame; lane k occupies bits [k*N_ADC +: N_ADC], lane 0 = oldest sample
frame_valid  out  1  frame_data holds the FIFO head
frame_ready  in  1  consumer accepts the head when frame_valid&&frame_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of frames currently stored
drop_cnt  out  DROP_CNT_W  dropped frames, saturating
overflow_sticky  out  1  set on the first drop, held until cleared
clr_stats  in  1  clears drop_cnt and overflow_sticky

Behaviour:
- Reset (rstb=0 at a clk edge): lane index idx=0, partial frame register=0, FIFO empty, frame_valid=0, frame_data=0, fifo_level=0, drop_cnt=0, overflow_sticky=0. Reset overrides all other inputs, including in the middle of a frame.
- Capture: on a cycle with in_valid=1, in_code is written to lane idx of the assembly register. idx then increments. Lanes hold codes bit-exact; there is no sign extension or arithmetic.
- Completion: when in_valid=1 and idx==N_WAYS-1, the frame is the assembly register with lane N_WAYS-1 replaced by in_code. It is pushed to the FIFO in that same edge, and idx wraps to 0.
- Latency: with the FIFO empty, frame_valid=1 and frame_data show the frame in the cycle after the edge that captured the last sample.
- in_valid=0: idx and the assembly register hold their values. Gaps in in_valid are allowed anywhere in a frame.
- align=1: idx is forced to 0 and the partial frame is discarded; this does not count as a drop.
  - align=1 with in_valid=1 in the same cycle: in_code becomes lane 0 of the new frame and idx becomes 1.
  - align=1 with N_WAYS==... (completion coincident): align wins; no frame is pushed.
- FIFO pop: happens when frame_valid&&frame_ready. frame_data presents the head combinationally from FIFO storage and is stable while frame_valid=1 and frame_ready=0.
- Full FIFO: a completed frame with fifo_level==FIFO_DEPTH and no pop in the same cycle is dropped. In that case drop_cnt increments (saturating at 2^DROP_CNT_W-1) and overflow_sticky is set. A push and pop in the same cycle while full both succeed and the level is unchanged.
- Empty FIFO: frame_valid=0 and frame_ready is ignored. A push into an empty FIFO is not visible until the next cycle; there is no fall-through.
- clr_stats=1: drop_cnt=0 and overflow_sticky=0. If a drop occurs in the same cycle, the result is drop_cnt=1 and overflow_sticky=1.
- fifo_level is updated at the edge: +1 on push only, -1 on pop only, unchanged for both or neither.

Decomposition:
- Package rx_adc_deser_pkg:
  - FRAME_W = N_WAYS*N_ADC helper function
  - LVL_W = $clog2(FIFO_DEPTH)+1
  - typedef of the signed code type
- Sub-module frame_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rstb, push, din, pop, dout, empty, full, level.
  - Pointers are wrap-around with one extra bit for full/empty detection.
- Top-level logic: lane counter, assembly register, drop/stat logic.

Test Plan:
- N_WAYS=4, codes 1,-2,3,-4 on consecutive cycles with frame_ready=1 → one cycle after the -4 edge, frame_valid=1 and frame_data=0xFC03FE01. It is popped in that cycle and fifo_level returns to 0.
- in_valid pattern 1,0,0,1,1,0,1 carrying codes 5,6,7,8 → a single frame with lanes {5,6,7,8}; idx holds across the gaps.
- Two samples 9,10, then align with in_valid=1 and code 11, then codes 12,13,14 → frame {11,12,13,14}; drop_cnt stays 0.
- FIFO_DEPTH=4, frame_ready=0, 6 complete frames → fifo_level=4, drop_cnt=2, overflow_sticky=1. Then frame_ready=1 → frames 1-4 come out in order.
- FIFO full with a completion and pop in the same cycle → fifo_level stays 4 and drop_cnt is unchanged. Then clr_stats coincident with a drop → drop_cnt=1 and overflow_sticky=1.
- rstb=0 asserted mid-frame and mid-FIFO (level 3) → next cycle all outputs are 0. After release, the first frame contains only post-reset samples.
